// File: rtl/data_sram_resp_pkg.sv
// Shared types and constants for the data SRAM responder.
package data_sram_resp_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam int          ERR_CNT_W          = 16;
  localparam int          DEFAULT_DEPTH_LOG2 = 10;
  localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h0000_0000;

endpackage

// File: rtl/data_sram_bank.sv
// Single-port word RAM with byte-lane write enables and a registered,
// read-first output (a write returns the word as it was before the write).
module data_sram_bank #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Responder side of the CPU SRAM bus: clears the RAM after reset, then serves
// 1-cycle reads/writes. Define DATA_SRAM_RESP_ERRCNT_EN to build the error counter.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sram_en,
  input  logic [3:0]           sram_we,
  input  logic [31:0]          sram_addr,
  input  logic [31:0]          sram_wdata,
  output logic [31:0]          sram_rdata,
  output logic                 init_done,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [32:0] SPAN = 33'd4 << DEPTH_LOG2;

  state_t                state, state_next;
  logic [DEPTH_LOG2-1:0] clear_idx;
  logic [31:0]           offset;
  logic                  in_range;
  logic                  resp_zero;
  logic                  bank_en;
  logic [3:0]            bank_we;
  logic [DEPTH_LOG2-1:0] bank_addr;
  logic [31:0]           bank_wdata;
  logic [31:0]           bank_rdata;

  assign offset   = sram_addr - BASE_ADDR;
  assign in_range = (sram_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);

  // CLEAR owns the RAM port and walks every word; SERVE hands it to the bus.
  always_comb begin
    state_next = state;
    bank_en    = 1'b0;
    bank_we    = 4'h0;
    bank_addr  = offset[DEPTH_LOG2+1:2];
    bank_wdata = sram_wdata;
    case (state)
      CLEAR: begin
        bank_en    = 1'b1;
        bank_we    = 4'hF;
        bank_addr  = clear_idx;
        bank_wdata = 32'h0;
        if (clear_idx == '1) state_next = SERVE;
      end
      SERVE: begin
        bank_en = sram_en && in_range;
        bank_we = sram_we;
      end
      default: state_next = CLEAR;
    endcase
    if (reset) bank_en = 1'b0;
  end

  // resp_zero masks the bank output whenever the last response must read as zero
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clear_idx <= '0;
      init_done <= 1'b0;
      resp_zero <= 1'b1;
    end else begin
      state     <= state_next;
      init_done <= (state == SERVE);
      if (state == CLEAR) begin
        clear_idx <= clear_idx + 1'b1;
        resp_zero <= 1'b1;
      end else if (sram_en) begin
        resp_zero <= !in_range;
      end
    end
  end

  assign sram_rdata = resp_zero ? 32'h0 : bank_rdata;

`ifdef DATA_SRAM_RESP_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else if ((state == SERVE) && sram_en && !in_range && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

  data_sram_bank #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bank (
    .clk  (clk),
    .en   (bank_en),
    .we   (bank_we),
    .addr (bank_addr),
    .wdata(bank_wdata),
    .rdata(bank_rdata)
  );

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: a 16-word instance at base 0 and a second
// instance at base 0x1000 for the address-window checks.
module tb_data_sram_resp;

`ifdef DATA_SRAM_RESP_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        init_done;
  logic [15:0] err_cnt;

  logic        en1;
  logic [31:0] addr1;
  logic [31:0] rdata1;
  logic        init1;
  logic [15:0] err1;

  int tests;
  int fails;

  data_sram_resp #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0000_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .init_done (init_done),
    .err_cnt   (err_cnt)
  );

  data_sram_resp #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0000_1000)) dut_base (
    .clk       (clk),
    .reset     (reset),
    .sram_en   (en1),
    .sram_we   (sram_we),
    .sram_addr (addr1),
    .sram_wdata(sram_wdata),
    .sram_rdata(rdata1),
    .init_done (init1),
    .err_cnt   (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    sram_en    = en;
    sram_we    = we;
    sram_addr  = addr;
    sram_wdata = wdata;
  endtask

  // Releases reset and returns the tick on which init_done first reads 1 (0 = timeout).
  task automatic wait_init(output int cycles);
    cycles = 0;
    reset  = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (init_done) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cycles;
    bit seen;
    reset = 1'b1;
    drive(1'b1, 4'h0, 32'h0, 32'h0);
    tick();
    tick();
    tests++;
    if (sram_rdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_rdata got %h want %h", sram_rdata, 32'h0); end
    tests++;
    if (init_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_init got %b want 0", init_done); end
    tests++;
    if (err_cnt !== 16'h0) begin fails++; $display("[TB] FAIL reset_err got %h want 0", err_cnt); end

    // Reads every cycle; early odd cycles go out of range and cycle 2 tries a write.
    reset  = 1'b0;
    cycles = 0;
    seen   = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      drive(1'b1, (i == 2) ? 4'hF : 4'h0, (i <= 10 && (i % 2) == 1) ? 32'h40 : 32'h0,
            32'hFFFF_FFFF);
      tick();
      if (i == 5) begin
        seen = 1'b1;
        tests++;
        if (sram_rdata !== 32'h0) begin fails++; $display("[TB] FAIL clear_rdata got %h want 0", sram_rdata); end
      end
      if (init_done) begin
        cycles = i;
        break;
      end
    end
    tests++;
    if (cycles != 17) begin fails++; $display("[TB] FAIL init_latency got %0d want 17", cycles); end
    tests++;
    if (sram_rdata !== 32'h0) begin fails++; $display("[TB] FAIL first_read got %h want 0", sram_rdata); end
    tests++;
    if (err_cnt !== 16'h0) begin fails++; $display("[TB] FAIL clear_err got %h want 0", err_cnt); end
    tests++;
    if (!seen || init1 !== 1'b1) begin fails++; $display("[TB] FAIL base_init got %b want 1", init1); end
  endtask

  task automatic test_byte_enable();
    drive(1'b1, 4'hF, 32'h8, 32'hDEAD_BEEF);
    tick();
    drive(1'b1, 4'b0010, 32'h8, 32'h0000_AA00);
    tick();
    tests++;
    if (sram_rdata !== 32'hDEAD_BEEF) begin fails++; $display("[TB] FAIL be_readfirst got %h want %h", sram_rdata, 32'hDEAD_BEEF); end
    drive(1'b1, 4'h0, 32'h8, 32'h0);
    tick();
    tests++;
    if (sram_rdata !== 32'hDEAD_AAEF) begin fails++; $display("[TB] FAIL be_merge got %h want %h", sram_rdata, 32'hDEAD_AAEF); end
  endtask

  task automatic test_read_after_write();
    drive(1'b1, 4'hF, 32'h4, 32'h1234_5678);
    tick();
    tests++;
    if (sram_rdata !== 32'h0) begin fails++; $display("[TB] FAIL raw_old got %h want 0", sram_rdata); end
    drive(1'b1, 4'h0, 32'h4, 32'h0);
    tick();
    tests++;
    if (sram_rdata !== 32'h1234_5678) begin fails++; $display("[TB] FAIL raw_new got %h want %h", sram_rdata, 32'h1234_5678); end
    drive(1'b0, 4'hF, 32'h8, 32'hFFFF_FFFF);
    tick();
    tick();
    tests++;
    if (sram_rdata !== 32'h1234_5678) begin fails++; $display("[TB] FAIL hold got %h want %h", sram_rdata, 32'h1234_5678); end
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 4'h0, 32'h40, 32'h0);
    tick();
    tests++;
    if (sram_rdata !== 32'h0) begin fails++; $display("[TB] FAIL oor_rdata got %h want 0", sram_rdata); end
    tests++;
    if (err_cnt !== (ERR_EN ? 16'd1 : 16'd0)) begin fails++; $display("[TB] FAIL oor_err1 got %h want %h", err_cnt, ERR_EN ? 16'd1 : 16'd0); end
    // A write that aliases word 1 must not land.
    drive(1'b1, 4'hF, 32'h44, 32'hBAD0_BAD0);
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    tests++;
    if (sram_rdata !== 32'h0) begin fails++; $display("[TB] FAIL oor_hold got %h want 0", sram_rdata); end
    tests++;
    if (err_cnt !== (ERR_EN ? 16'd2 : 16'd0)) begin fails++; $display("[TB] FAIL oor_err2 got %h want %h", err_cnt, ERR_EN ? 16'd2 : 16'd0); end
    drive(1'b1, 4'h0, 32'h4, 32'h0);
    tick();
    tests++;
    if (sram_rdata !== 32'h1234_5678) begin fails++; $display("[TB] FAIL oor_alias got %h want %h", sram_rdata, 32'h1234_5678); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'hF, 32'h10 + 32'(4 * i), 32'hA500_0000 + 32'(i));
      tick();
      tests++;
      if (sram_rdata !== 32'h0) begin fails++; $display("[TB] FAIL b2b_wr%0d got %h want 0", i, sram_rdata); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'h0, 32'h10 + 32'(4 * i), 32'h0);
      tick();
      tests++;
      if (sram_rdata !== 32'hA500_0000 + 32'(i)) begin
        fails++;
        $display("[TB] FAIL b2b_rd%0d got %h want %h", i, sram_rdata, 32'hA500_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_reset_restart();
    int cycles;
    drive(1'b1, 4'hF, 32'hC, 32'hCAFE_F00D);
    tick();
    reset = 1'b1;
    tick();
    wait_init(cycles);
    tests++;
    if (cycles != 17) begin fails++; $display("[TB] FAIL serve_reset_latency got %0d want 17", cycles); end
    drive(1'b1, 4'h0, 32'hC, 32'h0);
    tick();
    tests++;
    if (sram_rdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_cleared got %h want 0", sram_rdata); end
    tests++;
    if (err_cnt !== 16'h0) begin fails++; $display("[TB] FAIL reset_errclr got %h want 0", err_cnt); end

    // Reset in the middle of the clear walk restarts the full count.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b1;
    tick();
    wait_init(cycles);
    tests++;
    if (cycles != 17) begin fails++; $display("[TB] FAIL clear_reset_latency got %0d want 17", cycles); end
  endtask

  task automatic test_base();
    en1   = 1'b1;
    addr1 = 32'hFFC;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    tests++;
    if (rdata1 !== 32'h0 || err1 !== (ERR_EN ? 16'd1 : 16'd0)) begin
      fails++;
      $display("[TB] FAIL base_below got rdata %h err %h want 0 / %h", rdata1, err1, ERR_EN ? 16'd1 : 16'd0);
    end
    addr1 = 32'h1000;
    drive(1'b0, 4'hF, 32'h0, 32'h55AA_1234);
    tick();
    sram_we = 4'h0;
    tick();
    tests++;
    if (rdata1 !== 32'h55AA_1234) begin fails++; $display("[TB] FAIL base_word0 got %h want %h", rdata1, 32'h55AA_1234); end
    tests++;
    if (err1 !== (ERR_EN ? 16'd1 : 16'd0)) begin fails++; $display("[TB] FAIL base_err got %h want %h", err1, ERR_EN ? 16'd1 : 16'd0); end
    addr1 = 32'h1040;
    tick();
    tests++;
    if (rdata1 !== 32'h0 || err1 !== (ERR_EN ? 16'd2 : 16'd0)) begin
      fails++;
      $display("[TB] FAIL base_above got rdata %h err %h want 0 / %h", rdata1, err1, ERR_EN ? 16'd2 : 16'd0);
    end
    en1 = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    en1   = 1'b0;
    addr1 = 32'h0;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    test_reset();
    test_byte_enable();
    test_read_after_write();
    test_out_of_range();
    test_back_to_back();
    test_reset_restart();
    test_base();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
- REQ-001: Parameter DEPTH_LOG2, default 10; log2 of the RAM depth in 32-bit words.
- REQ-002: Parameter BASE_ADDR, default 32'h0000_0000; byte address of word 0, aligned to 4*2^DEPTH_LOG2.
- REQ-003: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: sram_en  input  1  access request in the current cycle.
- REQ-006: sram_we  input  4  byte write enables; 4'b0000 with sram_en=1 means read.
- REQ-007: sram_addr  input  32  byte address; bits [1:0] ignored.
- REQ-008: sram_wdata  input  32  write data; byte lane i = bits [8i+7:8i].
- REQ-009: sram_rdata  output  32  read data, registered.
- REQ-010: init_done  output  1  high once the clear sequence has completed.
- REQ-011: err_cnt  output  16  count of out-of-range accesses, saturating.

Function
- REQ-012: The block SHALL be the responder side of the CPU's en/we/addr/wdata/rdata SRAM interface, with fixed 1-cycle read latency and no back-pressure.
- REQ-013: The FSM SHALL have two states: CLEAR and SERVE. Reset enters CLEAR with clear index 0.
- REQ-014: In CLEAR, the block SHALL write 32'h0 to word [clear index] each cycle and then increment the index.
- REQ-015: After writing word 2^DEPTH_LOG2-1, the FSM SHALL go to SERVE, and init_done SHALL be 1 from the next cycle onward.
- REQ-016: In CLEAR, all requests SHALL be ignored: no RAM write, sram_rdata=0, err_cnt unchanged.
- REQ-017: An access is in range iff BASE_ADDR <= sram_addr < BASE_ADDR + 4*2^DEPTH_LOG2.
- REQ-018: Word index = sram_addr[DEPTH_LOG2+1:2] after the base offset is subtracted.
- REQ-019: Read in SERVE (sram_en=1, sram_we=0, in range): sram_rdata SHALL equal mem[word] in the next cycle.
- REQ-020: Write in SERVE (sram_en=1, sram_we!=0, in range): only the bytes with sram_we[i]=1 SHALL be updated at the edge.
- REQ-021: On a write, sram_rdata SHALL return the pre-write word in the next cycle (read-first).
- REQ-022: Out-of-range access in SERVE: no RAM write; sram_rdata=32'h0 next cycle; err_cnt +1, saturating at 16'hFFFF.
- REQ-023: With sram_en=0, sram_rdata SHALL hold its previous value.
- REQ-024: A read of a word written in the previous cycle SHALL return the new data.
- REQ-025: Back-to-back accesses every cycle SHALL be supported with no bubbles.

Reset
- REQ-026: When reset=1 at an edge: state=CLEAR, clear index=0, init_done=0, sram_rdata=32'h0, err_cnt=0.
- REQ-027: Reset asserted mid-CLEAR or mid-SERVE SHALL restart the full clear sequence.
- REQ-028: init_done SHALL first be 1 exactly 2^DEPTH_LOG2+1 cycles after the last reset edge.

Configuration
- REQ-029: Macro DATA_SRAM_RESP_ERRCNT_EN defined: err_cnt behaves per REQ-022.
- REQ-030: Macro DATA_SRAM_RESP_ERRCNT_EN undefined: err_cnt is tied to 16'h0 and no counter flops exist. Range checking, and the rdata=0 response, remain in effect.

Structure
- REQ-031: Package data_sram_resp_pkg SHALL hold the FSM state type (CLEAR, SERVE), the err_cnt width constant (16) and the default DEPTH_LOG2/BASE_ADDR constants.
- REQ-032: The RAM array SHALL be the sub-module data_sram_bank: one port, byte-enable write, registered read-first output, depth 2^DEPTH_LOG2.
- REQ-033: The FSM, range check, clear mux and error counter SHALL reside in data_sram_resp.

Verification (DEPTH_LOG2=4, BASE_ADDR=0 unless noted)
- REQ-034: Release reset; read 0x0 every cycle -> init_done=0 for 16 cycles, rises on cycle 17; first SERVE read returns 32'h0.
- REQ-035: Write 0x8 we=4'hF wdata=32'hDEADBEEF, then write 0x8 we=4'b0010 wdata=32'h0000AA00, then read 0x8 -> 32'hDEADAABEF is not valid; required 32'hDEADAAEF.
- REQ-036: Write 0x4 = 32'h12345678, immediately read 0x4 next cycle -> 32'h12345678; rdata during the write cycle response = 32'h0 (old).
- REQ-037: Read 0x40 (out of range) -> rdata 32'h0 and err_cnt=1; with the macro undefined -> err_cnt stays 0.
- REQ-038: Write 0xC = 32'hCAFEF00D, assert reset for 1 cycle, wait for init_done, read 0xC -> 32'h0, err_cnt=0.
- REQ-039: BASE_ADDR=32'h1000: read 0xFFC -> error; read 0x1000 -> word 0 returned, err_cnt unchanged.
